softmax_feeder: RTL and testbench

- Sits between the core array global-bus read side and the consmax softmax bus.
- Captures per-head score words returned on gbus_rdata/gbus_rvalid from a programmable subset of columns.
- Buffers them in per-head FIFOs and issues them as softmax idata/idata_valid beats, either per head independently or lock-stepped across all heads.
- Counts a programmed number of words per head and reports completion and error conditions.

---
 rtl/softmax_feeder.sv | 136 +++++++++++++
 tb/tb_softmax_feeder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/softmax_feeder.sv
// rtl/softmax_feeder.sv - captures per-head gbus read words into FIFOs and issues them as softmax beats
module softmax_feeder #(
  parameter int HNUM       = 8,
  parameter int VNUM       = 8,
  parameter int GBUS_DATA  = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_BIT    = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [CNT_BIT-1:0]        cfg_word_num,
  input  logic                      cfg_sync_mode,
  input  logic [VNUM-1:0]           cfg_col_mask,
  input  logic [HNUM*GBUS_DATA-1:0] gbus_rdata,
  input  logic [HNUM*VNUM-1:0]      gbus_rvalid,
  output logic [HNUM*GBUS_DATA-1:0] softmax_idata,
  output logic [HNUM-1:0]           softmax_idata_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      err_multi
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]        PTR_ONE = 1;
  localparam logic [CNT_BIT-1:0] CNT_ONE = 1;
  localparam logic [VNUM-1:0]    V_ONE   = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  logic [CNT_BIT-1:0] word_num;
  logic               sync_mode;
  logic [VNUM-1:0]    col_mask;

  logic [CNT_BIT-1:0]   cap_cnt  [HNUM];
  logic [CNT_BIT-1:0]   emit_cnt [HNUM];
  logic [PW:0]          wr_ptr   [HNUM];
  logic [PW:0]          rd_ptr   [HNUM];
  logic [GBUS_DATA-1:0] mem      [HNUM][FIFO_DEPTH];

  logic [HNUM-1:0] hit, multi, empty, full, active, cap_ok, pop, push, drop;
  logic            run, all_ready;

  for (genvar h = 0; h < HNUM; h++) begin : g_head
    logic [VNUM-1:0] masked;
    assign masked    = gbus_rvalid[h*VNUM +: VNUM] & col_mask;
    assign hit[h]    = |masked;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi[h]  = |(masked & (masked - V_ONE));
    assign empty[h]  = (wr_ptr[h] == rd_ptr[h]);
    assign full[h]   = (wr_ptr[h][PW] != rd_ptr[h][PW]) &&
                       (wr_ptr[h][PW-1:0] == rd_ptr[h][PW-1:0]);
    assign active[h] = (emit_cnt[h] < word_num);
    assign cap_ok[h] = (cap_cnt[h] != word_num);
  end

  assign run       = (state == S_RUN);
  // Heads that have finished emitting do not hold back the lock-stepped pop.
  assign all_ready = &(~active | ~empty);
  assign pop       = {HNUM{run}} & active & (sync_mode ? {HNUM{all_ready}} : ~empty);
  assign push      = {HNUM{run}} & hit & cap_ok & ~(full & ~pop);
  assign drop      = {HNUM{run}} & hit & ~push;

  always_ff @(posedge clk) begin
    for (int h = 0; h < HNUM; h++) begin
      if (push[h]) mem[h][wr_ptr[h][PW-1:0]] <= gbus_rdata[h*GBUS_DATA +: GBUS_DATA];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      word_num            <= '0;
      sync_mode           <= 1'b0;
      col_mask            <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      overflow            <= 1'b0;
      err_multi           <= 1'b0;
      softmax_idata       <= '0;
      softmax_idata_valid <= '0;
      for (int h = 0; h < HNUM; h++) begin
        cap_cnt[h]  <= '0;
        emit_cnt[h] <= '0;
        wr_ptr[h]   <= '0;
        rd_ptr[h]   <= '0;
      end
    end else begin
      done                <= 1'b0;
      softmax_idata_valid <= pop;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            word_num  <= cfg_word_num;
            sync_mode <= cfg_sync_mode;
            col_mask  <= cfg_col_mask;
            overflow  <= 1'b0;
            err_multi <= 1'b0;
            for (int h = 0; h < HNUM; h++) begin
              cap_cnt[h]  <= '0;
              emit_cnt[h] <= '0;
              wr_ptr[h]   <= '0;
              rd_ptr[h]   <= '0;
            end
          end
        end
        S_RUN: begin
          if (|drop)       overflow  <= 1'b1;
          if (|(hit & multi)) err_multi <= 1'b1;
          if (&(~active)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      for (int h = 0; h < HNUM; h++) begin
        if (push[h]) begin
          wr_ptr[h]  <= wr_ptr[h] + PTR_ONE;
          cap_cnt[h] <= cap_cnt[h] + CNT_ONE;
        end
        if (pop[h]) begin
          rd_ptr[h]   <= rd_ptr[h] + PTR_ONE;
          emit_cnt[h] <= emit_cnt[h] + CNT_ONE;
          softmax_idata[h*GBUS_DATA +: GBUS_DATA] <= mem[h][rd_ptr[h][PW-1:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_softmax_feeder.sv
// tb/tb_softmax_feeder.sv - scoreboard bench for softmax_feeder (2 heads, 2 columns, depth 4)
module tb_softmax_feeder;
  localparam int HNUM = 2;
  localparam int VNUM = 2;
  localparam int DW   = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_start;
  logic [11:0]          cfg_word_num;
  logic                 cfg_sync_mode;
  logic [VNUM-1:0]      cfg_col_mask;
  logic [HNUM*DW-1:0]   gbus_rdata;
  logic [HNUM*VNUM-1:0] gbus_rvalid;
  logic [HNUM*DW-1:0]   softmax_idata;
  logic [HNUM-1:0]      softmax_idata_valid;
  logic                 busy, done, overflow, err_multi;

  int checks = 0;
  int errors = 0;
  logic sync_chk = 1'b0;
  logic [DW-1:0] exp_q [HNUM][$];

  softmax_feeder #(.HNUM(HNUM), .VNUM(VNUM), .GBUS_DATA(DW), .FIFO_DEPTH(4), .CNT_BIT(12)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_word_num(cfg_word_num),
    .cfg_sync_mode(cfg_sync_mode), .cfg_col_mask(cfg_col_mask), .gbus_rdata(gbus_rdata),
    .gbus_rvalid(gbus_rvalid), .softmax_idata(softmax_idata),
    .softmax_idata_valid(softmax_idata_valid), .busy(busy), .done(done),
    .overflow(overflow), .err_multi(err_multi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every beat must match the next queued word for its head.
  always @(negedge clk) begin
    for (int h = 0; h < HNUM; h++) begin
      if (softmax_idata_valid[h]) begin
        if (exp_q[h].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat head%0d: got 0x%0h with nothing expected", h,
                   softmax_idata[h*DW +: DW]);
        end else begin
          check($sformatf("beat_data_h%0d", h), 32'(softmax_idata[h*DW +: DW]), 32'(exp_q[h].pop_front()));
        end
      end
    end
    if (sync_chk && |softmax_idata_valid)
      check("sync_lockstep", 32'(softmax_idata_valid), 32'b11);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    gbus_rvalid = '0;
  endtask

  task automatic push(input int h, input int c, input logic [DW-1:0] d, input bit expect_beat);
    gbus_rvalid[h*VNUM+c] = 1'b1;
    gbus_rdata[h*DW +: DW] = d;
    if (expect_beat) exp_q[h].push_back(d);
  endtask

  task automatic start(input logic [11:0] wn, input logic sm, input logic [VNUM-1:0] mask);
    cfg_word_num  = wn;
    cfg_sync_mode = sm;
    cfg_col_mask  = mask;
    cfg_start     = 1'b1;
    cyc();
    cfg_start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 60) begin
      cyc();
      n++;
    end
    check({name, "_done_seen"}, 32'(done), 32'd1);
    check({name, "_busy_low_at_done"}, 32'(busy), 32'd0);
    cyc();
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_queue0_drained"}, 32'(exp_q[0].size()), 32'd0);
    check({name, "_queue1_drained"}, 32'(exp_q[1].size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_word_num = '0; cfg_sync_mode = 1'b0;
    cfg_col_mask = '0; gbus_rdata = '0; gbus_rvalid = '0;
    cyc(); cyc();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_flags", {30'd0, overflow, err_multi}, 0);
    check("rst_valid", 32'(softmax_idata_valid), 0);
    check("rst_data", 32'(softmax_idata), 0);
    rst = 1'b0;
    cyc();

    // Independent mode, head1 trails head0 by four cycles.
    start(3, 1'b0, 2'b01);
    check("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 7; i++) begin
      if (i < 3)  push(0, 0, 16'h11 * 16'(i + 1), 1'b1);
      if (i >= 4) push(1, 0, 16'hA1 + 16'(i - 4), 1'b1);
      cyc();
      if (i == 0) check("t1_lat_not_early", 32'(softmax_idata_valid[0]), 0);
      if (i == 1) check("t1_lat_two_cycles", 32'(softmax_idata_valid[0]), 1);
    end
    wait_done("t1");

    // Lock-step mode: nothing may issue until head1 has data.
    sync_chk = 1'b1;
    start(2, 1'b1, 2'b01);
    for (int i = 0; i < 7; i++) begin
      if (i < 2)  push(0, 0, 16'hB1 + 16'(i), 1'b1);
      if (i >= 5) push(1, 0, 16'hC1 + 16'(i - 5), 1'b1);
      cyc();
      if (i == 5) check("t2_no_beat_before_h1", 32'(softmax_idata_valid), 0);
    end
    wait_done("t2");
    sync_chk = 1'b0;

    // Unmasked column is ignored; masked column completes the transfer.
    start(2, 1'b0, 2'b10);
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 16'hDEAD, 1'b0);
      push(1, 0, 16'hBEEF, 1'b0);
      cyc();
    end
    cyc(); cyc();
    check("t3_busy_held", 32'(busy), 1);
    for (int i = 0; i < 2; i++) begin
      push(0, 1, 16'hE0 + 16'(i), 1'b1);
      push(1, 1, 16'hF0 + 16'(i), 1'b1);
      cyc();
    end
    wait_done("t3");

    // Full FIFO overflow, multi-column error, push accepted on full with simultaneous pop.
    sync_chk = 1'b1;
    start(5, 1'b1, 2'b11);
    for (int i = 0; i < 6; i++) begin
      push(0, 0, 16'h40 + 16'(i), i < 4);
      cyc();
      if (i == 3) check("t4_no_overflow_at_4", 32'(overflow), 0);
      if (i == 4) check("t4_overflow_at_5", 32'(overflow), 1);
    end
    check("t4_no_err_yet", 32'(err_multi), 0);
    push(0, 0, 16'h4F, 1'b0);
    push(0, 1, 16'h4F, 1'b0);
    cyc();
    check("t4_err_multi", 32'(err_multi), 1);
    for (int i = 0; i < 5; i++) begin
      push(1, 0, 16'h50 + 16'(i), 1'b1);
      if (i == 1) push(0, 0, 16'h45, 1'b1);
      cyc();
    end
    wait_done("t4");
    sync_chk = 1'b0;
    check("t4_sticky_flags", {30'd0, overflow, err_multi}, 32'b11);

    // Word beyond word_num is dropped.
    start(2, 1'b0, 2'b01);
    check("t5_flags_cleared", {30'd0, overflow, err_multi}, 0);
    for (int i = 0; i < 3; i++) begin
      push(0, 0, 16'h60 + 16'(i), i < 2);
      if (i < 2) push(1, 0, 16'h70 + 16'(i), 1'b1);
      cyc();
      if (i == 1) check("t5_no_overflow_yet", 32'(overflow), 0);
    end
    check("t5_overflow_extra", 32'(overflow), 1);
    wait_done("t5");

    // Mid-transfer reset, then a zero-length transfer.
    start(4, 1'b1, 2'b01);
    push(0, 0, 16'h81, 1'b0); cyc();
    push(0, 0, 16'h82, 1'b0); cyc();
    rst = 1'b1;
    cyc();
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_valid", 32'(softmax_idata_valid), 0);
    check("t6_rst_done", 32'(done), 0);
    rst = 1'b0;
    cyc();
    start(0, 1'b0, 2'b01);
    check("t6_zero_busy", 32'(busy), 1);
    check("t6_zero_no_done", 32'(done), 0);
    cyc();
    check("t6_zero_busy_low", 32'(busy), 0);
    check("t6_zero_done", 32'(done), 1);
    cyc();
    check("t6_zero_done_clear", 32'(done), 0);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
